spi_master: RTL and testbench

SPI master (initiator) that drives the other end of the team's `spi_slave`. It accepts one byte from the host on a write strobe and clocks it out MSB-first on `mosi` in SPI mode 0 (CPOL=0, CPHA=0). It samples `miso` in parallel and presents the received byte on `out_data` when the transfer completes. It sits between the system bus logic and the off-block SPI pins, one chip select, one slave.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sclk_div.sv | 37 +++
 rtl/spi_master.sv | 145 ++++++++++++++
 tb/tb_spi_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word width and a
// helper that keeps counter widths legal when a range collapses to one value.
package spi_pkg;

   typedef enum logic [2:0] {
      SPI_IDLE,
      SPI_ASSERT,
      SPI_SCLK_HI,
      SPI_SCLK_LO,
      SPI_DEASSERT
   } spi_state_e;

   localparam int unsigned SPI_DATA_W = 8;

   // $clog2(1) is 0; a zero-width counter is not representable.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter for the SPI master: tick marks the last clk cycle of
// each CLK_DIV-cycle period; restart holds the count at zero.
module spi_sclk_div
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   // Clearing on tick restarts the count for the state the FSM enters.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one word per accepted wr, MSB first, full duplex,
// single chip select. Every non-idle state lasts CLK_DIV cycles.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned DATA_W  = SPI_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              wr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              cs,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso
);

   localparam int unsigned BW = cnt_width(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              cs_q, cs_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tick;
   logic              restart;

   // Counter idles at zero so ASSERT gets a full CLK_DIV period.
   assign restart = (state_q == SPI_IDLE);

   spi_sclk_div #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      out_d   = out_q;
      bit_d   = bit_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         SPI_IDLE: begin
            if (wr) begin
               tx_d    = in_data;
               mosi_d  = in_data[DATA_W-1];
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               bit_d   = '0;
               state_d = SPI_ASSERT;
            end
         end
         SPI_ASSERT, SPI_SCLK_LO: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_d    = {rx_q[DATA_W-2:0], miso};
               state_d = SPI_SCLK_HI;
            end
         end
         SPI_SCLK_HI: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bit_q == LAST_BIT) begin
                  state_d = SPI_DEASSERT;
               end else begin
                  tx_d    = {tx_q[DATA_W-2:0], 1'b0};
                  mosi_d  = tx_q[DATA_W-2];
                  bit_d   = bit_q + 1'b1;
                  state_d = SPI_SCLK_LO;
               end
            end
         end
         SPI_DEASSERT: begin
            if (tick) begin
               cs_d    = 1'b1;
               mosi_d  = 1'b0;
               busy_d  = 1'b0;
               out_d   = rx_q;
               done_d  = 1'b1;
               state_d = SPI_IDLE;
            end
         end
         default: begin
            state_d = SPI_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SPI_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         out_q   <= '0;
         bit_q   <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         out_q   <= out_d;
         bit_q   <= bit_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_data = out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cs       = cs_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;

   done_one_cycle: assert property (@(posedge clk) disable iff (rst) done |=> !done);
   cs_tracks_busy: assert property (@(posedge clk) disable iff (rst) busy == !cs);

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance 0 runs CLK_DIV=2, instance 1 CLK_DIV=1;
// expected transfers are queued at issue and checked when done pulses.
module tb_spi_master;
   import spi_pkg::*;

   localparam int unsigned W = SPI_DATA_W;

   typedef struct {
      int unsigned  inst;
      logic [W-1:0] tx;
      logic [W-1:0] rx;
      int unsigned  lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   logic         rst        [2];
   logic         wr         [2];
   logic [W-1:0] in_data    [2];
   logic         loop       [2];
   logic [W-1:0] slave_byte [2];
   logic         busy_w     [2];
   logic         done_w     [2];
   logic         cs_w       [2];
   logic         sclk_w     [2];
   logic         mosi_w     [2];
   logic         miso_w     [2];
   logic [W-1:0] out_w      [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int unsigned D = (g == 0) ? 2 : 1;

      logic [W-1:0]         sreg     = '0;
      logic [$clog2(W)-1:0] sidx     = '1;
      logic [W-1:0]         mosi_cap = '0;
      int unsigned          rises     = 0;
      int unsigned          start_cyc = 0;
      bit                   cs_bad    = 1'b0;
      bit                   prev_done = 1'b0;
      exp_t                 e;

      spi_master #(
         .CLK_DIV(D),
         .DATA_W (W)
      ) dut (
         .clk     (clk),
         .rst     (rst[g]),
         .in_data (in_data[g]),
         .wr      (wr[g]),
         .out_data(out_w[g]),
         .busy    (busy_w[g]),
         .done    (done_w[g]),
         .cs      (cs_w[g]),
         .sclk    (sclk_w[g]),
         .mosi    (mosi_w[g]),
         .miso    (miso_w[g])
      );

      // Slave model: MSB on cs fall, next bit after each sclk fall.
      assign miso_w[g] = loop[g] ? mosi_w[g] : sreg[sidx];

      always @(negedge cs_w[g]) begin
         sreg = slave_byte[g];
         sidx = '1;
      end

      always @(negedge sclk_w[g]) begin
         if (cs_w[g] === 1'b0 && sidx != 0) sidx = sidx - 1'b1;
      end

      always @(posedge clk) begin
         if (!rst[g] && wr[g] === 1'b1 && busy_w[g] === 1'b0) begin
            start_cyc = cyc;
            rises     = 0;
            cs_bad    = 1'b0;
            mosi_cap  = '0;
         end
      end

      always @(posedge sclk_w[g]) begin
         mosi_cap = {mosi_cap[W-2:0], mosi_w[g]};
         rises++;
      end

      always @(negedge clk) begin
         if (prev_done)
            check($sformatf("u%0d done width", g), 32'(done_w[g]), 32'd0);
         prev_done = done_w[g];
         if (busy_w[g] === 1'b1 && cs_w[g] !== 1'b0) cs_bad = 1'b1;
         if (done_w[g] === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u%0d unexpected done: out_data 0x%0h, no transfer queued",
                        g, out_w[g]);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("u%0d instance", g), 32'(g), e.inst);
               check($sformatf("u%0d out_data", g), 32'(out_w[g]), 32'(e.rx));
               check($sformatf("u%0d mosi bits", g), 32'(mosi_cap), 32'(e.tx));
               check($sformatf("u%0d done latency", g), cyc - start_cyc - 1, e.lat);
               check($sformatf("u%0d sclk rises", g), rises, 32'(W));
               check($sformatf("u%0d cs low while busy", g), 32'(cs_bad), 32'd0);
               check($sformatf("u%0d end pins cs/busy/mosi", g),
                     {29'd0, cs_w[g], busy_w[g], mosi_w[g]}, 32'b100);
            end
         end
      end
   end

   function automatic logic [31:0] pins(input int g);
      return 32'({cs_w[g], sclk_w[g], mosi_w[g], busy_w[g], done_w[g], out_w[g]});
   endfunction

   task automatic expect_xfer(input int g, input logic [W-1:0] tx, input logic [W-1:0] rx,
                              input int unsigned lat);
      exp_t x;
      x.inst = g;
      x.tx   = tx;
      x.rx   = rx;
      x.lat  = lat;
      exp_q.push_back(x);
   endtask

   // Caller is positioned at a negedge.
   task automatic drive_wr(input int g, input logic [W-1:0] b);
      in_data[g] = b;
      wr[g]      = 1'b1;
      @(posedge clk);
      #1 wr[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done_w[g] === 1'b1) seen = 1'b1;
      end
      check($sformatf("u%0d done seen", g), 32'(seen), 32'd1);
   endtask

   logic [31:0] idle_pins;
   int          busy_cnt;
   int          nrise;
   logic        prev_sclk;

   initial begin
      idle_pins = 32'({1'b1, {(W + 4){1'b0}}});
      for (int g = 0; g < 2; g++) begin
         rst[g]        = 1'b1;
         wr[g]         = 1'b0;
         in_data[g]    = '0;
         loop[g]       = 1'b1;
         slave_byte[g] = '0;
      end
      repeat (3) @(negedge clk);
      check("u0 reset pins", pins(0), idle_pins);
      check("u1 reset pins", pins(1), idle_pins);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      repeat (2) @(negedge clk);

      // Loopback
      expect_xfer(0, 8'hBB, 8'hBB, 34);
      drive_wr(0, 8'hBB);
      wait_done(0);
      repeat (2) @(negedge clk);

      // Slave returns 0x5A
      loop[0]       = 1'b0;
      slave_byte[0] = 8'h5A;
      expect_xfer(0, 8'hFF, 8'h5A, 34);
      drive_wr(0, 8'hFF);
      wait_done(0);
      loop[0] = 1'b1;
      repeat (2) @(negedge clk);

      // Back-to-back: second wr in the done cycle
      expect_xfer(0, 8'h22, 8'h22, 34);
      drive_wr(0, 8'h22);
      wait_done(0);
      check("b2b cs high in done cycle", 32'(cs_w[0]), 32'd1);
      expect_xfer(0, 8'h33, 8'h33, 34);
      drive_wr(0, 8'h33);
      check("b2b second accepted", 32'(busy_w[0]), 32'd1);
      wait_done(0);
      repeat (2) @(negedge clk);

      // wr while busy is ignored
      expect_xfer(0, 8'h22, 8'h22, 34);
      drive_wr(0, 8'h22);
      repeat (10) @(negedge clk);
      drive_wr(0, 8'h33);
      wait_done(0);
      busy_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy_w[0] !== 1'b0) busy_cnt++;
      end
      check("busy ignore no second transfer", 32'(busy_cnt), 32'd0);

      // Reset after the 4th sclk rise
      @(negedge clk);
      drive_wr(0, 8'h3C);
      nrise     = 0;
      prev_sclk = 1'b0;
      for (int i = 0; i < 200 && nrise < 4; i++) begin
         @(negedge clk);
         if (sclk_w[0] === 1'b1 && prev_sclk === 1'b0) nrise++;
         prev_sclk = sclk_w[0];
      end
      check("abort reached 4th rise", 32'(nrise), 32'd4);
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      check("abort pins", pins(0), idle_pins);
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (2) @(negedge clk);
      expect_xfer(0, 8'hA5, 8'hA5, 34);
      drive_wr(0, 8'hA5);
      wait_done(0);
      repeat (2) @(negedge clk);

      // CLK_DIV=1 corner
      expect_xfer(1, 8'h81, 8'h81, 17);
      drive_wr(1, 8'h81);
      wait_done(1);
      repeat (3) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
